mem_port_arbiter: RTL and testbench

- Arbitrates the single-port unified SRAM in the memory stage between two requesters: instruction fetch (PC-addressed) and the data port (load/store).
- Drives the memory stage's address-select, fetch address, data address, write data and write-enable inputs.
- Routes the SRAM's one-cycle-delayed read data back to the requester that owns the read.
- Sits between the fetch unit / MEM pipeline stage and the memory stage. Its ack outputs are the pipeline's stall sources.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the load/store port.
// Optional MEM_ARB_RR_EN: strict alternation under contention instead of data priority with starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        mem_clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_ack,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_select,
    output logic [29:0] mem_pc,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
        $error("mem_port_arbiter: ADDR_W must be in 1..30");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } rd_own_t;

    rd_own_t rd_own;
    logic    last_grant_if;   // 1 = last ack went to fetch
    logic    grant_if;
    logic    grant_d;

`ifndef MEM_ARB_RR_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);
    logic [3:0] starve_cnt;
`endif

    // Contention tie-break is the only place the two build flavours differ.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                if (!last_grant_if) grant_if = 1'b1;
                else                grant_d  = 1'b1;
`else
                if (starve_cnt == STARVE_MAX) grant_if = 1'b1;
                else                          grant_d  = 1'b1;
`endif
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            rd_own        <= OWN_NONE;
            last_grant_if <= 1'b1;
`ifndef MEM_ARB_RR_EN
            starve_cnt    <= 4'd0;
`endif
        end else begin
            if (grant_if)               rd_own <= OWN_IF;
            else if (grant_d && !d_we)  rd_own <= OWN_D;
            else                        rd_own <= OWN_NONE;

            last_grant_if <= grant_if ? 1'b1 : (grant_d ? 1'b0 : last_grant_if);
`ifndef MEM_ARB_RR_EN
            if (!if_req || grant_if)        starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
`endif
        end
    end

    assign if_ack     = grant_if;
    assign d_ack      = grant_d;
    assign mem_select = !grant_d;
    assign mem_wren   = grant_d && d_we;
    assign mem_pc     = if_addr;
    assign mem_addr   = d_addr;
    assign mem_wdata  = d_wdata;

    // Gating with reset drops a read that was in flight when reset rose.
    assign if_rvalid = !reset && (rd_own == OWN_IF);
    assign d_rvalid  = !reset && (rd_own == OWN_D);
    assign if_rdata  = if_rvalid ? mem_q : 32'd0;
    assign d_rdata   = d_rvalid  ? mem_q : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; inputs driven 1ns after posedge, outputs checked at negedge.
module tb_mem_port_arbiter;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_ack;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_select;
    logic [29:0] mem_pc;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_q;

    int nvec = 0;
    int nerr = 0;

    always #5 mem_clk = ~mem_clk;

    mem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
        .mem_clk(mem_clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_select(mem_select), .mem_pc(mem_pc), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge mem_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 30'h5; d_addr = 30'h6; d_wdata = 32'h1; mem_q = 32'hFFFF_FFFF;
        step(); step(); mid();
        nvec++; if (if_ack !== 1'b0) begin nerr++; $display("FAIL reset_if_ack got %b want 0", if_ack); end
        nvec++; if (d_ack !== 1'b0) begin nerr++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
        nvec++; if (mem_wren !== 1'b0) begin nerr++; $display("FAIL reset_wren got %b want 0", mem_wren); end
        nvec++; if (mem_select !== 1'b1) begin nerr++; $display("FAIL reset_select got %b want 1", mem_select); end
        nvec++; if ({if_rvalid, d_rvalid} !== 2'b00) begin nerr++; $display("FAIL reset_rvalid got %b want 00", {if_rvalid, d_rvalid}); end
        nvec++; if ({if_rdata, d_rdata} !== 64'd0) begin nerr++; $display("FAIL reset_rdata got %h want 0", {if_rdata, d_rdata}); end
        step();
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_q = 32'd0;
        mid();
        nvec++; if ({if_ack, d_ack, mem_select, mem_wren} !== 4'b0010) begin nerr++; $display("FAIL idle_drive got %b want 0010", {if_ack, d_ack, mem_select, mem_wren}); end
    endtask

    task automatic test_lone_fetch();
        step();
        if_req = 1'b1; if_addr = 30'h3FFF_F010;
        mid();
        nvec++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin nerr++; $display("FAIL fetch_ack got %b%b want 10", if_ack, d_ack); end
        nvec++; if (mem_select !== 1'b1) begin nerr++; $display("FAIL fetch_select got %b want 1", mem_select); end
        nvec++; if (mem_pc !== 30'h3FFF_F010) begin nerr++; $display("FAIL fetch_pc got %h want 3ffff010", mem_pc); end
        step();
        if_req = 1'b0; mem_q = 32'hDEAD_BEEF;
        mid();
        nvec++; if (if_rvalid !== 1'b1) begin nerr++; $display("FAIL fetch_rvalid got %b want 1", if_rvalid); end
        nvec++; if (if_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL fetch_rdata got %h want deadbeef", if_rdata); end
        nvec++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin nerr++; $display("FAIL fetch_d_quiet got %b/%h want 0/0", d_rvalid, d_rdata); end
        step();
        mid();
        nvec++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin nerr++; $display("FAIL fetch_rvalid_drop got %b/%h want 0/0", if_rvalid, if_rdata); end
    endtask

    task automatic test_store_load();
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'h1234_5678; mem_q = 32'd0;
        mid();
        nvec++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin nerr++; $display("FAIL store_ack got %b%b want 01", if_ack, d_ack); end
        nvec++; if (mem_wren !== 1'b1 || mem_select !== 1'b0) begin nerr++; $display("FAIL store_drive got wren=%b sel=%b want 1/0", mem_wren, mem_select); end
        nvec++; if (mem_addr !== 30'h20 || mem_wdata !== 32'h1234_5678) begin nerr++; $display("FAIL store_bus got %h/%h want 20/12345678", mem_addr, mem_wdata); end
        step();
        d_we = 1'b0;
        mid();
        nvec++; if (d_rvalid !== 1'b0) begin nerr++; $display("FAIL store_no_rvalid got %b want 0", d_rvalid); end
        nvec++; if (d_ack !== 1'b1 || mem_wren !== 1'b0) begin nerr++; $display("FAIL load_ack got ack=%b wren=%b want 1/0", d_ack, mem_wren); end
        step();
        d_req = 1'b0; mem_q = 32'h1234_5678;
        mid();
        nvec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin nerr++; $display("FAIL load_data got %b/%h want 1/12345678", d_rvalid, d_rdata); end
        nvec++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin nerr++; $display("FAIL load_if_quiet got %b/%h want 0/0", if_rvalid, if_rdata); end
    endtask

    // Both ports loading continuously; exp bit i = 1 when fetch wins cycle i.
    task automatic test_contention();
        logic [7:0] exp_if;
        logic       prev_if;
`ifdef MEM_ARB_RR_EN
        exp_if = 8'b1010_1010;
        step(); reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        step(); reset = 1'b0;
        step();
`else
        exp_if = 8'b1000_1000;
        step();
`endif
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 30'h100; d_addr = 30'h200;
        for (int i = 0; i < 8; i++) begin
            mem_q = 32'hA000_0000 + 32'(i);
            mid();
            nvec++; if ({if_ack, d_ack} !== {exp_if[i], ~exp_if[i]}) begin nerr++; $display("FAIL contend_grant[%0d] got %b%b want %b%b", i, if_ack, d_ack, exp_if[i], ~exp_if[i]); end
            if (i > 0) begin
                nvec++; if ({if_rvalid, d_rvalid} !== {prev_if, ~prev_if}) begin nerr++; $display("FAIL contend_owner[%0d] got %b%b want %b%b", i, if_rvalid, d_rvalid, prev_if, ~prev_if); end
                nvec++; if ((prev_if ? if_rdata : d_rdata) !== 32'hA000_0000 + 32'(i)) begin nerr++; $display("FAIL contend_rdata[%0d] got %h/%h want %h", i, if_rdata, d_rdata, 32'hA000_0000 + 32'(i)); end
            end
            prev_if = exp_if[i];
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

`ifndef MEM_ARB_RR_EN
    // A fetch gap must clear the starvation count.
    task automatic test_starve_clear();
        logic [6:0] exp_if;
        logic [6:0] ifr;
        exp_if = 7'b100_0000;
        ifr    = 7'b111_1011;
        step();
        d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if_req = ifr[i];
            mid();
            nvec++; if ({if_ack, d_ack} !== {exp_if[i], ~exp_if[i]}) begin nerr++; $display("FAIL starve_clear[%0d] got %b%b want %b%b", i, if_ack, d_ack, exp_if[i], ~exp_if[i]); end
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_read();
        step();
        if_req = 1'b1; if_addr = 30'h40; d_req = 1'b0;
        mid();
        nvec++; if (if_ack !== 1'b1) begin nerr++; $display("FAIL rmr_grant0 got %b want 1", if_ack); end
        step();
        reset = 1'b1; d_req = 1'b1; d_we = 1'b1; mem_q = 32'hCAFE_F00D;
        mid();
        nvec++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin nerr++; $display("FAIL rmr_rvalid1 got %b/%h want 0/0", if_rvalid, if_rdata); end
        nvec++; if ({if_ack, d_ack, mem_wren, mem_select} !== 4'b0001) begin nerr++; $display("FAIL rmr_outputs got %b want 0001", {if_ack, d_ack, mem_wren, mem_select}); end
        step();
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        mid();
        nvec++; if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL rmr_rvalid2 got %b want 0", if_rvalid); end
        nvec++; if (if_ack !== 1'b1) begin nerr++; $display("FAIL rmr_regrant got %b want 1", if_ack); end
        step();
        if_req = 1'b0; mem_q = 32'h0BAD_CAFE;
        mid();
        nvec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BAD_CAFE) begin nerr++; $display("FAIL rmr_rvalid3 got %b/%h want 1/0badcafe", if_rvalid, if_rdata); end
    endtask

    task automatic test_back_to_back();
        step();
        d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_addr = 30'(i + 1);
            if (i == 3) d_req = 1'b0;
            mem_q = (i > 0) ? 32'h5500_0000 + 32'(i) : 32'd0;
            mid();
            if (i < 3) begin
                nvec++; if (d_ack !== 1'b1 || mem_addr !== 30'(i + 1)) begin nerr++; $display("FAIL b2b_ack[%0d] got %b@%h want 1@%h", i, d_ack, mem_addr, 30'(i + 1)); end
            end
            if (i > 0) begin
                nvec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5500_0000 + 32'(i)) begin nerr++; $display("FAIL b2b_data[%0d] got %b/%h want 1/%h", i, d_rvalid, d_rdata, 32'h5500_0000 + 32'(i)); end
            end else begin
                nvec++; if (d_rvalid !== 1'b0) begin nerr++; $display("FAIL b2b_data[0] got %b want 0", d_rvalid); end
            end
            step();
        end
        mid();
        nvec++; if (d_rvalid !== 1'b0 || d_ack !== 1'b0) begin nerr++; $display("FAIL b2b_tail got %b%b want 00", d_rvalid, d_ack); end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
`ifndef MEM_ARB_RR_EN
        test_starve_clear();
`endif
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
